// File: rtl/idwt_haar_pipelined_top.sv
// Pipelined one-level inverse Haar DWT: rebuilds N samples from N/2 (cA, cD) pairs,
// one pair per clock through snapshot -> S0 (lane fetch) -> S1 (x181) -> S2 (butterfly) -> store.
module idwt_haar_pipelined_top #(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [16*(N/2)-1:0] cA_in,
  input  logic [16*(N/2)-1:0] cD_in,
  output logic [16*N-1:0]     array_out,
  output logic                busy,
  output logic                done
);

  localparam int L  = N / 2;
  localparam int KW = (L > 1) ? $clog2(L) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(L - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [KW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            snap_ld, issue;

  logic [16*L-1:0] snap_ca_q, snap_cd_q;

  logic            s0_vld_q;
  logic [KW-1:0]   s0_k_q;
  logic [15:0]     s0_ca_q, s0_cd_q;

  logic            s1_vld_q;
  logic [KW-1:0]   s1_k_q;
  logic [31:0]     s1_a_q, s1_d_q;

  logic            s2_vld_q;
  logic [KW-1:0]   s2_k_q;
  logic [15:0]     s2_x0_q, s2_x1_q;

  logic [16*N-1:0] out_q;

  // x * 181 as shift-adds: 128 + 32 + 16 + 4 + 1
  function automatic logic [31:0] mul181(input logic [15:0] v);
    logic [31:0] z;
    z = {16'd0, v};
    return (z << 7) + (z << 5) + (z << 4) + (z << 2) + z;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    snap_ld = 1'b0;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          busy_d  = 1'b1;
          snap_ld = 1'b1;
        end
      end
      S_RUN: begin
        issue = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == K_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Completion is keyed on the lane index travelling with the data.
        if (s2_vld_q && (s2_k_q == K_LAST)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_ca_q <= '0;
      snap_cd_q <= '0;
      s0_vld_q  <= 1'b0;
      s0_k_q    <= '0;
      s0_ca_q   <= '0;
      s0_cd_q   <= '0;
      s1_vld_q  <= 1'b0;
      s1_k_q    <= '0;
      s1_a_q    <= '0;
      s1_d_q    <= '0;
      s2_vld_q  <= 1'b0;
      s2_k_q    <= '0;
      s2_x0_q   <= '0;
      s2_x1_q   <= '0;
      out_q     <= '0;
    end else begin
      if (snap_ld) begin
        snap_ca_q <= cA_in;
        snap_cd_q <= cD_in;
      end

      s0_vld_q <= issue;
      if (issue) begin
        s0_k_q  <= cnt_q;
        s0_ca_q <= snap_ca_q[16*cnt_q +: 16];
        s0_cd_q <= snap_cd_q[16*cnt_q +: 16];
      end

      s1_vld_q <= s0_vld_q;
      if (s0_vld_q) begin
        s1_k_q <= s0_k_q;
        s1_a_q <= mul181(s0_ca_q);
        s1_d_q <= mul181(s0_cd_q);
      end

      // Sum and difference wrap mod 2^32; the sample is bits [23:8].
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_k_q  <= s1_k_q;
        s2_x0_q <= 16'((s1_a_q + s1_d_q) >> 8);
        s2_x1_q <= 16'((s1_a_q - s1_d_q) >> 8);
      end

      if (s2_vld_q) begin
        out_q[32*s2_k_q      +: 16] <= s2_x0_q;
        out_q[32*s2_k_q + 16 +: 16] <= s2_x1_q;
      end
    end
  end

  assign array_out = out_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_idwt_haar_pipelined_top.sv
// Bench for idwt_haar_pipelined_top (N=8): expected lane results are queued at start
// and popped on the exact cycle each lane is due in array_out.
module tb_idwt_haar_pipelined_top;
  localparam int N = 8;
  localparam int L = N / 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [16*L-1:0] cA_in, cD_in;
  logic [16*N-1:0] array_out;
  logic            busy, done;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          k;
    logic [15:0] x0;
    logic [15:0] x1;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  idwt_haar_pipelined_top #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cA_in    (cA_in),
    .cD_in    (cD_in),
    .array_out(array_out),
    .busy     (busy),
    .done     (done)
  );

  function automatic logic [15:0] ref_inv(input logic [15:0] ca, input logic [15:0] cd, input bit odd);
    logic [31:0] a, d, r;
    a = 32'(ca) * 32'd181;
    d = 32'(cd) * 32'd181;
    r = odd ? (a - d) : (a + d);
    return r[23:8];
  endfunction

  function automatic logic [15:0] ref_fwd(input logic [15:0] x0, input logic [15:0] x1, input bit det);
    logic [31:0] s;
    s = det ? (32'(x0) - 32'(x1)) : (32'(x0) + 32'(x1));
    s = s * 32'd181;
    return s[23:8];
  endfunction

  function automatic logic [16*L-1:0] rand_lanes();
    logic [16*L-1:0] v;
    for (int k = 0; k < L; k++) v[16*k +: 16] = 16'($urandom);
    return v;
  endfunction

  // One complete operation. hold keeps start high throughout; poke re-asserts start mid-RUN.
  task automatic run(input logic [16*L-1:0] ca, input logic [16*L-1:0] cd,
                     input bit hold, input bit poke, input string name);
    logic [16*N-1:0] prev;
    exp_t e;
    prev = array_out;
    for (int k = 0; k < L; k++) begin
      e.k  = k;
      e.x0 = ref_inv(ca[16*k +: 16], cd[16*k +: 16], 1'b0);
      e.x1 = ref_inv(ca[16*k +: 16], cd[16*k +: 16], 1'b1);
      sb.push_back(e);
    end
    cA_in = ca;
    cD_in = cd;
    start = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL %s accept_busy: got %b exp 1", name, busy);
    end
    if (!hold) start = 1'b0;
    // Scramble the inputs; results must come from the snapshot.
    cA_in = rand_lanes();
    cD_in = rand_lanes();
    for (int c = 1; c <= L + 3; c++) begin
      if (poke && c == 2) begin start = 1'b1; cA_in = rand_lanes(); end
      if (poke && c == 3) start = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (busy !== (c < L + 3)) begin
        fails++; $display("FAIL %s busy@e0+%0d: got %b exp %b", name, c, busy, (c < L + 3));
      end
      tests++;
      if (done !== (c == L + 3)) begin
        fails++; $display("FAIL %s done@e0+%0d: got %b exp %b", name, c, done, (c == L + 3));
      end
      for (int k = 0; k < L; k++) begin
        if (c < 4 + k) begin
          tests++;
          if (array_out[32*k +: 32] !== prev[32*k +: 32]) begin
            fails++;
            $display("FAIL %s lane%0d_early@e0+%0d: got %h exp %h", name, k, c,
                     array_out[32*k +: 32], prev[32*k +: 32]);
          end
        end else if (c == 4 + k) begin
          tests++;
          if (sb.size() == 0) begin
            fails++; $display("FAIL %s sb_empty lane%0d: got 0 entries exp >=1", name, k);
          end else begin
            e = sb.pop_front();
            if (e.k !== k || array_out[32*k +: 16] !== e.x0 || array_out[32*k+16 +: 16] !== e.x1) begin
              fails++;
              $display("FAIL %s lane%0d@e0+%0d: got %h,%h exp lane%0d %h,%h", name, k, c,
                       array_out[32*k +: 16], array_out[32*k+16 +: 16], e.k, e.x0, e.x1);
            end
          end
        end
      end
    end
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL %s sb_leftover: got %0d exp 0", name, sb.size());
    end
    if (!hold) begin
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL %s release: got done=%b busy=%b exp 0 0", name, done, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cA_in = '0; cD_in = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (array_out !== '0) begin fails++; $display("FAIL reset_array: got %h exp 0", array_out); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b exp 0", busy); end
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b exp 0", done); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || array_out !== '0) begin
      fails++; $display("FAIL idle_after_reset: got busy=%b done=%b out=%h exp 0", busy, done, array_out);
    end
  endtask

  task automatic test_dc();
    run({L{16'h0100}}, '0, 1'b0, 1'b0, "dc");
    tests++;
    if (array_out !== {N{16'h00B5}}) begin
      fails++; $display("FAIL dc_all: got %h exp all 00b5", array_out);
    end
  endtask

  task automatic test_lane_mix();
    run(64'h0000_0000_0000_0100, 64'h0000_0000_0100_0100, 1'b0, 1'b0, "lane_mix");
    tests++;
    if (array_out !== 128'h0000_0000_0000_0000_FF4B_00B5_0000_016A) begin
      fails++; $display("FAIL lane_mix_all: got %h exp 0000000000000000ff4b00b50000016a", array_out);
    end
  endtask

  task automatic test_per_lane_timing();
    for (int i = 0; i < 3; i++) run(rand_lanes(), rand_lanes(), 1'b0, 1'b0, "timing");
  endtask

  task automatic test_handshake();
    logic [16*N-1:0] held;
    run(rand_lanes(), rand_lanes(), 1'b1, 1'b0, "hold");
    held = array_out;
    for (int i = 0; i < 4; i++) begin
      cA_in = rand_lanes(); cD_in = rand_lanes();
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b1 || busy !== 1'b0 || array_out !== held) begin
        fails++; $display("FAIL hold_done cyc%0d: got done=%b busy=%b out=%h exp 1 0 %h",
                          i, done, busy, array_out, held);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL drop_start_done: got %b exp 0", done); end
    run(rand_lanes(), rand_lanes(), 1'b0, 1'b0, "rerun");
    run(rand_lanes(), rand_lanes(), 1'b0, 1'b1, "poke");
    held = array_out;
    repeat (4) begin
      @(posedge clk); #1;
      tests++;
      if (busy !== 1'b0 || array_out !== held) begin
        fails++; $display("FAIL poke_no_retrigger: got busy=%b out=%h exp 0 %h", busy, array_out, held);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    cA_in = rand_lanes(); cD_in = rand_lanes(); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (array_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL mid_reset_async: got out=%h busy=%b done=%b exp 0 0 0", array_out, busy, done);
    end
    #3;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    tests++;
    if (array_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL mid_reset_idle: got out=%h busy=%b done=%b exp 0 0 0", array_out, busy, done);
    end
    run({L{16'h0100}}, '0, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_round_trip();
    logic [15:0] xs [N];
    logic [16*L-1:0] ca, cd;
    int diff;
    for (int it = 0; it < 4; it++) begin
      // Range keeps the x181 scaling drift inside +-2 LSB; even sample >= odd keeps cD non-negative,
      // since cD is zero-extended on the way in.
      for (int k = 0; k < L; k++) begin
        if (it == 0) begin
          xs[2*k] = 16'h0100; xs[2*k+1] = 16'h0100;
        end else begin
          xs[2*k]   = 16'($urandom_range(0, 16'h0A00));
          xs[2*k+1] = 16'($urandom_range(0, int'(xs[2*k])));
        end
        ca[16*k +: 16] = ref_fwd(xs[2*k], xs[2*k+1], 1'b0);
        cd[16*k +: 16] = ref_fwd(xs[2*k], xs[2*k+1], 1'b1);
      end
      run(ca, cd, 1'b0, 1'b0, "round_trip");
      for (int j = 0; j < N; j++) begin
        diff = int'(array_out[16*j +: 16]) - int'(xs[j]);
        tests++;
        if (diff > 2 || diff < -2) begin
          fails++; $display("FAIL rt_tol it%0d s%0d: got %h exp %h +-2", it, j, array_out[16*j +: 16], xs[j]);
        end
      end
      if (it == 0) begin
        tests++;
        if (array_out !== {N{16'h00FF}}) begin
          fails++; $display("FAIL rt_0100: got %h exp all 00ff", array_out);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_dc();
    test_lane_mix();
    test_per_lane_timing();
    test_handshake();
    test_reset_mid_run();
    test_round_trip();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
